time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//   Sequences user time entry for the clock datapath (12/24 h clocks, stopwatch preset).
//   Walks hours -> minutes -> seconds fields with up/down buttons and holds working values.
//   Emits a one-cycle load_o strobe on commit; the clock counters sample Hourset/Minset/Secset then.
//   Sits between the debounced buttons and the digital_clk_* / stopwatch set inputs.
// PARAMETERS
//   INIT_HRS     11     hours value after reset, 0..23
//   INIT_MIN     35     minutes value after reset, 0..59
//   INIT_SEC     42     seconds value after reset, 0..59
//   TIMEOUT_MS   10000  idle 1 kHz ticks in an EDIT state before the edit is aborted
//   REPEAT_DLY   500    ticks a held up/down waits before auto-repeat starts (AUTOREPEAT_EN only)
//   REPEAT_RATE  100    ticks between auto-repeat steps (AUTOREPEAT_EN only)
// PORTS
//   clk_i        in   1  system clock
//   reset_i      in   1  asynchronous, active-low reset
//   tick_i       in   1  1 kHz single-cycle enable from clock_divider_1khz, synchronous to clk_i
//   btn_mode_i   in   1  enter edit / abort; debounced level, synchronous to clk_i
//   btn_next_i   in   1  advance field; debounced level
//   btn_up_i     in   1  increment current field; debounced level
//   btn_dn_i     in   1  decrement current field; debounced level
//   set_hrs_o    out  6  working hours value
//   set_min_o    out  6  working minutes value
//   set_sec_o    out  6  working seconds value
//   load_o       out  1  one-cycle commit strobe
//   editing_o    out  1  high in any EDIT state
//   field_o      out  2  field being edited: 0 none, 1 hrs, 2 min, 3 sec (drives display blink)
// BEHAVIOUR
//   - Reset: state IDLE; set_* = INIT_* values; shadow = INIT_*; load_o, editing_o, field_o = 0.
//   - Buttons act on their rising edge (registered previous level), one clk_i cycle after the edge.
//   - Edge priority in one cycle: mode > next > up/down. Up and down together: no change.
//   - States IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
//       IDLE   + mode -> EDIT_H; copy set_* into shadow.
//       EDIT_x + next -> next field; EDIT_S + next -> COMMIT.
//       EDIT_x + mode -> IDLE; restore set_* from shadow; no load_o.
//       COMMIT -> IDLE after one cycle; load_o = 1 in that cycle only.
//   - Up/down wrap: hrs 23 -> 0 and 0 -> 23; min/sec 59 -> 0 and 0 -> 59. Values never leave range.
//   - Timeout counter clears on any button edge and on entry to an EDIT state; counts tick_i.
//     Reaching TIMEOUT_MS aborts exactly like mode (restore shadow, no load_o).
//   - Edges in IDLE other than mode are ignored. Edges during COMMIT are ignored.
//   - Reset asserted mid-edit: immediate return to the reset values above; shadow is discarded.
// CONFIGURATION
//   AUTOREPEAT_EN defined: up/down held continuously for REPEAT_DLY ticks produces one step,
//     then one step every REPEAT_RATE ticks until release. Wrap rules apply to every step.
//   AUTOREPEAT_EN undefined: exactly one step per press; repeat counters are not built.
// STRUCTURE
//   time_pkg: state encoding, FIELD_* codes, HRS_MAX=23, MIN_MAX=59, SEC_MAX=59.
//   Sub-module btn_edge: per-button edge register, plus the hold counter when AUTOREPEAT_EN.
//   Instanced four times. Field wrap-arithmetic stays inline in time_set_ctrl.
// TESTING
//   - Reset low -> set_* = 11/35/42; load_o = 0; editing_o = 0; field_o = 0.
//   - Sequence mode, up x3, next, dn x36, next, next -> set_* = 14/59/42.
//     load_o is high for exactly 1 cycle; field_o returns to 0.
//   - EDIT_H at 23, then up -> 0. EDIT_M at 0, then dn -> 59. EDIT_S at 59, then up -> 0.
//   - Mode, up x2, then mode again -> set_* restored to 11/35/42; load_o never asserted.
//   - Mode, then 10000 ticks with no buttons -> back in IDLE with values restored, no load.
//     Also: up and dn rising in the same cycle -> value unchanged.
//   - With AUTOREPEAT_EN: hold up for 800 ticks in EDIT_M starting at 35
//     -> steps at 500, 600, 700, 800 -> 39.
//     Without the macro, the same stimulus -> 36.

Source files
------------

// File: rtl/time_pkg.sv
// time_pkg: shared types and constants for the time-entry controller.
//   state_t   : controller states (IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT)
//   FIELD_*   : codes driven on field_o (0 none, 1 hrs, 2 min, 3 sec)
//   *_MAX     : upper bound of each time field; values wrap past these
package time_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_H,
    EDIT_M,
    EDIT_S,
    COMMIT
  } state_t;

  typedef logic [1:0] field_t;

  localparam field_t FIELD_NONE = 2'd0;
  localparam field_t FIELD_HRS  = 2'd1;
  localparam field_t FIELD_MIN  = 2'd2;
  localparam field_t FIELD_SEC  = 2'd3;

  localparam logic [5:0] HRS_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for one debounced button level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   tick       : 1 kHz single-cycle enable (used only for auto-repeat)
//   level      : debounced button level
//   rise       : registered one-cycle pulse after a rising edge of level
//   step       : one-cycle step request for up/down use
// Configuration macro: AUTOREPEAT_EN
//   undefined : step equals rise (one step per press), no hold counter built
//   defined   : step fires after level is held REPEAT_DLY ticks, then every
//               REPEAT_RATE ticks until release
module btn_edge #(
  parameter int unsigned REPEAT_DLY  = 500,
  parameter int unsigned REPEAT_RATE = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  output logic rise,
  output logic step
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned CMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  logic [CW-1:0] hold_cnt;
  logic          armed;

  // armed selects between the initial delay and the repeat interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      armed    <= 1'b0;
      step     <= 1'b0;
    end else begin
      step <= 1'b0;
      if (!level) begin
        hold_cnt <= '0;
        armed    <= 1'b0;
      end else if (tick) begin
        if (hold_cnt == (armed ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DLY - 1))) begin
          step     <= 1'b1;
          hold_cnt <= '0;
          armed    <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused;
  assign unused = tick ^ (REPEAT_DLY == 0) ^ (REPEAT_RATE == 0);
  assign step   = rise;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: user time-entry sequencer for the clock datapath.
//   Walks hours -> minutes -> seconds with up/down buttons, keeps a shadow
//   copy for abort, and pulses load_o for one cycle on commit.
// Ports:
//   clk_i      : system clock
//   reset_i    : asynchronous active-low reset
//   tick_i     : 1 kHz single-cycle enable
//   btn_mode_i : enter edit / abort (debounced level)
//   btn_next_i : advance field (debounced level)
//   btn_up_i   : increment current field (debounced level)
//   btn_dn_i   : decrement current field (debounced level)
//   set_hrs_o, set_min_o, set_sec_o : working time values
//   load_o     : one-cycle commit strobe
//   editing_o  : high in any EDIT state
//   field_o    : field being edited (0 none, 1 hrs, 2 min, 3 sec)
// Configuration macro: AUTOREPEAT_EN (auto-repeat of held up/down, in btn_edge)
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int unsigned INIT_HRS    = 11,
  parameter int unsigned INIT_MIN    = 35,
  parameter int unsigned INIT_SEC    = 42,
  parameter int unsigned TIMEOUT_MS  = 10000,
  parameter int unsigned REPEAT_DLY  = 500,
  parameter int unsigned REPEAT_RATE = 100
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       btn_mode_i,
  input  logic       btn_next_i,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  output logic [5:0] set_hrs_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       load_o,
  output logic       editing_o,
  output logic [1:0] field_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_MS + 1);

  state_t        state;
  logic [5:0]    shadow_hrs, shadow_min, shadow_sec;
  logic [TW-1:0] to_cnt;

  logic mode_rise, next_rise, up_rise, dn_rise;
  logic up_step, dn_step;
  logic mode_step_unused, next_step_unused;
  logic any_edge, timeout;

  btn_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_mode (
    .clk(clk_i), .rst_n(reset_i), .tick(tick_i), .level(btn_mode_i),
    .rise(mode_rise), .step(mode_step_unused)
  );
  btn_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_next (
    .clk(clk_i), .rst_n(reset_i), .tick(tick_i), .level(btn_next_i),
    .rise(next_rise), .step(next_step_unused)
  );
  btn_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk_i), .rst_n(reset_i), .tick(tick_i), .level(btn_up_i),
    .rise(up_rise), .step(up_step)
  );
  btn_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .clk(clk_i), .rst_n(reset_i), .tick(tick_i), .level(btn_dn_i),
    .rise(dn_rise), .step(dn_step)
  );

  // Auto-repeat steps count as button activity so a long hold never times out.
  assign any_edge = mode_rise | next_rise | up_rise | dn_rise | up_step | dn_step;
  // An edge in the same cycle as the final tick clears the counter instead.
  assign timeout  = tick_i & ~any_edge & (to_cnt == TW'(TIMEOUT_MS - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      set_hrs_o  <= 6'(INIT_HRS);
      set_min_o  <= 6'(INIT_MIN);
      set_sec_o  <= 6'(INIT_SEC);
      shadow_hrs <= 6'(INIT_HRS);
      shadow_min <= 6'(INIT_MIN);
      shadow_sec <= 6'(INIT_SEC);
      load_o     <= 1'b0;
      editing_o  <= 1'b0;
      field_o    <= FIELD_NONE;
      to_cnt     <= '0;
    end else begin
      load_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_rise) begin
            shadow_hrs <= set_hrs_o;
            shadow_min <= set_min_o;
            shadow_sec <= set_sec_o;
            state      <= EDIT_H;
            editing_o  <= 1'b1;
            field_o    <= FIELD_HRS;
            to_cnt     <= '0;
          end
        end

        EDIT_H, EDIT_M, EDIT_S: begin
          if (mode_rise || timeout) begin
            set_hrs_o <= shadow_hrs;
            set_min_o <= shadow_min;
            set_sec_o <= shadow_sec;
            state     <= IDLE;
            editing_o <= 1'b0;
            field_o   <= FIELD_NONE;
            to_cnt    <= '0;
          end else if (next_rise) begin
            to_cnt <= '0;
            case (state)
              EDIT_H: begin
                state   <= EDIT_M;
                field_o <= FIELD_MIN;
              end
              EDIT_M: begin
                state   <= EDIT_S;
                field_o <= FIELD_SEC;
              end
              default: begin
                state     <= COMMIT;
                load_o    <= 1'b1;
                editing_o <= 1'b0;
                field_o   <= FIELD_NONE;
              end
            endcase
          end else if (up_step ^ dn_step) begin
            to_cnt <= '0;
            case (state)
              EDIT_H: begin
                if (up_step) set_hrs_o <= (set_hrs_o >= HRS_MAX) ? 6'd0 : set_hrs_o + 6'd1;
                else         set_hrs_o <= (set_hrs_o == 6'd0) ? HRS_MAX : set_hrs_o - 6'd1;
              end
              EDIT_M: begin
                if (up_step) set_min_o <= (set_min_o >= MIN_MAX) ? 6'd0 : set_min_o + 6'd1;
                else         set_min_o <= (set_min_o == 6'd0) ? MIN_MAX : set_min_o - 6'd1;
              end
              default: begin
                if (up_step) set_sec_o <= (set_sec_o >= SEC_MAX) ? 6'd0 : set_sec_o + 6'd1;
                else         set_sec_o <= (set_sec_o == 6'd0) ? SEC_MAX : set_sec_o - 6'd1;
              end
            endcase
          end else if (any_edge) begin
            to_cnt <= '0;
          end else if (tick_i) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        COMMIT: state <= IDLE;

        default: begin
          state     <= IDLE;
          editing_o <= 1'b0;
          field_o   <= FIELD_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, tick_i, btn_mode, btn_next, btn_up, btn_dn;
  logic [5:0] set_hrs, set_min, set_sec;
  logic       load, editing;
  logic [1:0] field;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i),
    .btn_mode_i(btn_mode), .btn_next_i(btn_next), .btn_up_i(btn_up), .btn_dn_i(btn_dn),
    .set_hrs_o(set_hrs), .set_min_o(set_min), .set_sec_o(set_sec),
    .load_o(load), .editing_o(editing), .field_o(field)
  );

  // Reference model: field values as plain integers with modulo wrap.
  int m_val[3];
  int m_shadow[3];
  int m_field;
  bit m_edit;
  int m_loads = 0;

  int   load_seen = 0;
  int   load_long = 0;
  logic load_prev = 1'b0;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_seen++;
      if (load_prev === 1'b1) load_long++;
    end
    load_prev = load;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int modulus(input int f);
    return (f == 1) ? 24 : 60;
  endfunction

  task automatic model_reset();
    m_val    = '{11, 35, 42};
    m_shadow = '{11, 35, 42};
    m_field  = 0;
    m_edit   = 0;
  endtask

  task automatic model_abort();
    m_val   = m_shadow;
    m_edit  = 0;
    m_field = 0;
  endtask

  // kind: 0 mode, 1 next, 2 up, 3 dn, 4 up+dn together
  task automatic model_act(input int kind);
    if (!m_edit) begin
      if (kind == 0) begin
        m_shadow = m_val;
        m_edit   = 1;
        m_field  = 1;
      end
    end else begin
      case (kind)
        0: model_abort();
        1: begin
          if (m_field == 3) begin
            m_edit  = 0;
            m_field = 0;
            m_loads++;
          end else m_field++;
        end
`ifndef AUTOREPEAT_EN
        2: m_val[m_field-1] = (m_val[m_field-1] + 1) % modulus(m_field);
        3: m_val[m_field-1] = (m_val[m_field-1] + modulus(m_field) - 1) % modulus(m_field);
`endif
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_hrs"}, set_hrs, m_val[0]);
    check({tag, "_min"}, set_min, m_val[1]);
    check({tag, "_sec"}, set_sec, m_val[2]);
    check({tag, "_editing"}, editing, m_edit);
    check({tag, "_field"}, field, m_field);
    check({tag, "_loads"}, load_seen, m_loads);
  endtask

  task automatic press(input int kind);
    @(negedge clk);
    case (kind)
      0: btn_mode = 1'b1;
      1: btn_next = 1'b1;
      2: btn_up   = 1'b1;
      3: btn_dn   = 1'b1;
      default: begin
        btn_up = 1'b1;
        btn_dn = 1'b1;
      end
    endcase
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    repeat (3) @(negedge clk);
    model_act(kind);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk) tick_i = 1'b1;
      @(negedge clk) tick_i = 1'b0;
    end
  endtask

  int exp_min;

  initial begin
    reset_i  = 1'b0;
    tick_i   = 1'b0;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_hrs", set_hrs, 11);
    check("rst_min", set_min, 35);
    check("rst_sec", set_sec, 42);
    check("rst_load", load, 0);
    check("rst_editing", editing, 0);
    check("rst_field", field, 0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);

    // Edges in IDLE other than mode are ignored
    press(1); press(2); press(3);
    check_model("idle_ignore");

    // Abort via mode restores values, no load
    press(0);
    check("edit_field", field, 1);
    press(2); press(2);
    press(0);
    check("abort_hrs", set_hrs, 11);
    check("abort_min", set_min, 35);
    check("abort_sec", set_sec, 42);
    check("abort_loads", load_seen, 0);
    check_model("abort");

    // Main commit sequence
    press(0);
    repeat (3) press(2);
    press(1);
    repeat (36) press(3);
    press(1);
    check_model("seq_sec_field");
    press(1);
    check_model("seq_commit");
`ifndef AUTOREPEAT_EN
    check("seq_hrs", set_hrs, 14);
    check("seq_min", set_min, 59);
    check("seq_sec", set_sec, 42);
`endif
    check("seq_load_count", load_seen, 1);
    check("seq_field_idle", field, 0);

    // Wrap boundaries
    press(0);
    for (int i = 0; i < 24 && m_val[0] != 23; i++) press(2);
    check_model("hrs_at_23");
    press(2);
    check_model("hrs_wrap_up");
    press(1);
    for (int i = 0; i < 60 && m_val[1] != 0; i++) press(3);
    check_model("min_at_0");
    press(3);
    check_model("min_wrap_dn");
    press(1);
    for (int i = 0; i < 60 && m_val[2] != 59; i++) press(2);
    press(2);
    check_model("sec_wrap_up");
`ifndef AUTOREPEAT_EN
    check("hrs_wrap_const", set_hrs, 0);
    check("min_wrap_const", set_min, 59);
    check("sec_wrap_const", set_sec, 0);
`endif
    press(0);
    check_model("wrap_abort");

    // Up and down together: no change
    press(0);
    press(4);
    check_model("both_hrs");
    press(1);
    press(4);
    check_model("both_min");
    press(0);

    // Timeout: one tick short stays in edit, the final tick aborts
    press(0);
    press(2);
    tick_n(9999);
    check_model("timeout_minus1");
    tick_n(1);
    repeat (2) @(negedge clk);
    model_abort();
    check_model("timeout_abort");

    // Randomised button sequences
    for (int i = 0; i < 80; i++) begin
      int r;
      int kind;
      r = $urandom_range(0, 9);
      kind = (r == 0) ? 0 : (r <= 2) ? 1 : (r <= 5) ? 2 : (r <= 8) ? 3 : 4;
      press(kind);
      check_model($sformatf("rand%0d", i));
    end

    // Reset mid-edit: immediate return to reset values, shadow discarded
    if (!m_edit) press(0);
    press(2);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("midrst_hrs", set_hrs, 11);
    check("midrst_min", set_min, 35);
    check("midrst_sec", set_sec, 42);
    check("midrst_editing", editing, 0);
    check("midrst_field", field, 0);
    @(negedge clk);
    reset_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    press(0);
    press(0);
    check_model("post_rst_abort");

    // Held up in EDIT_M starting at 35 for 800 ticks
    press(0);
    press(1);
    @(negedge clk) btn_up = 1'b1;
    repeat (3) @(negedge clk);
    tick_n(800);
    btn_up = 1'b0;
    repeat (3) @(negedge clk);
`ifdef AUTOREPEAT_EN
    exp_min = 35 + 1 + (800 - 500) / 100;
`else
    exp_min = 36;
`endif
    m_val[1] = exp_min;
    check("hold_min", set_min, exp_min);
    check_model("hold");
    press(0);
    check_model("hold_abort");

    check("load_pulse_width", load_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
